// File: rtl/pipe_pkg.sv
// Shared types and constants for the handshaked pipeline stage register.
// Storage-state encoding, performance counter width, default control bubble.
// No logic; imported by pipe_stage_reg and pipe_perf_ctr.
package pipe_pkg;

  // Occupancy of the stage: main entry only, or main plus skid entry.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_st_e;

  localparam int PERF_CNT_W = 32;

  // All-zero control is a no-op bubble: no register write, no memory write.
  localparam logic [15:0] CTRL_BUBBLE_DEF = 16'h0000;

endpackage

// File: rtl/pipe_perf_ctr.sv
// Saturating event counter with synchronous clear.
// Latency: count reflects an event on the edge after it is seen.
// No backpressure; holds at all-ones instead of wrapping.
module pipe_perf_ctr
  import pipe_pkg::*;
#(
  parameter int W = PERF_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count events, clear on request, stick at the maximum value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with a 2-entry skid buffer and flush-to-bubble.
// Latency: 1 cycle in_valid->out_valid when empty; 1 beat/cycle sustained.
// Backpressure: in_ready is registered and low only while both entries are held.
// Optional PIPE_STAGE_PERF_EN adds saturating stall/backpressure/flush counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                CTRL_W      = 16,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_BUBBLE_DEF),
  parameter logic [DATA_W-1:0] DATA_RST    = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_stall_cnt,
  output logic [PERF_CNT_W-1:0] perf_bp_cnt,
  output logic [PERF_CNT_W-1:0] perf_flush_cnt
`endif
);

  stage_st_e         r_state;
  stage_st_e         w_state_nxt;
  logic              r_in_ready;
  logic              w_in_ready_nxt;
  logic              w_out_valid;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = w_out_valid & out_ready;

  // State register; in_ready is registered alongside so out_ready never reaches it combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= w_in_ready_nxt;
    end
  end

  // Next-state: flush always empties the stage, otherwise track occupancy.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY:   if (w_in_xfer) w_state_nxt = ONE;
        ONE: begin
          if (w_in_xfer && !w_out_xfer)      w_state_nxt = FULL;
          else if (!w_in_xfer && w_out_xfer) w_state_nxt = EMPTY;
        end
        FULL:    if (w_out_xfer) w_state_nxt = ONE;
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // Outputs derived from state: main-entry valid and next-cycle acceptance.
  always_comb begin
    w_out_valid    = (r_state != EMPTY);
    w_in_ready_nxt = (w_state_nxt != FULL);
  end

  // Entry storage: load main/skid on accepted input, promote skid on drain, scrub on flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_data <= DATA_RST;
      r_main_ctrl <= CTRL_BUBBLE;
      r_skid_data <= DATA_RST;
      r_skid_ctrl <= CTRL_BUBBLE;
    end else if (flush) begin
      r_main_data <= DATA_RST;
      r_main_ctrl <= CTRL_BUBBLE;
      r_skid_data <= DATA_RST;
      r_skid_ctrl <= CTRL_BUBBLE;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
          end
        end
        ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
          end else if (w_in_xfer) begin
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
          end
        end
        FULL: begin
          if (w_out_xfer) begin
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
            r_skid_data <= DATA_RST;
            r_skid_ctrl <= CTRL_BUBBLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_main_data;
  // Control is masked at the output so a drained entry's stale control is never seen.
  assign out_ctrl  = w_out_valid ? r_main_ctrl : CTRL_BUBBLE;

`ifdef PIPE_STAGE_PERF_EN
  logic w_stall_ev;
  logic w_bp_ev;
  logic w_flush_ev;

  assign w_stall_ev = w_out_valid & ~out_ready;
  assign w_bp_ev    = in_valid & ~r_in_ready;
  // Main is always occupied when anything is held, so its valid covers "killed an entry".
  assign w_flush_ev = flush & w_out_valid;

  pipe_perf_ctr #(.W(PERF_CNT_W)) u_stall_ctr (
    .clk   (clk),
    .reset (reset),
    .i_clr (1'b0),
    .i_inc (w_stall_ev),
    .o_cnt (perf_stall_cnt)
  );

  pipe_perf_ctr #(.W(PERF_CNT_W)) u_bp_ctr (
    .clk   (clk),
    .reset (reset),
    .i_clr (1'b0),
    .i_inc (w_bp_ev),
    .o_cnt (perf_bp_cnt)
  );

  pipe_perf_ctr #(.W(PERF_CNT_W)) u_flush_ctr (
    .clk   (clk),
    .reset (reset),
    .i_clr (1'b0),
    .i_inc (w_flush_ev),
    .o_cnt (perf_flush_cnt)
  );
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, streaming, skid fill/drain, flush, async reset.
// Outputs sampled on the falling edge; inputs driven just after sampling.
// Non-default bubble/reset patterns make bubble forcing visible.
module tb_pipe_stage_reg;

  localparam logic [15:0] BUB  = 16'h0BB0;
  localparam logic [31:0] DRST = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [15:0] in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_ctrl;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_bp_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W      (32),
    .CTRL_W      (16),
    .CTRL_BUBBLE (BUB),
    .DATA_RST    (DRST)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_bp_cnt    (perf_bp_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [15:0] c);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 16'h0);

    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_ctrl",  32'(out_ctrl),  32'(BUB));
    chk("rst_out_data",  out_data,       DRST);
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_in_ready",  32'(in_ready),  32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Single beat, 1-cycle latency
    drive(1'b1, 32'h1234, 16'h00A5); out_ready = 1'b1;
    tick();
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_out_data",  out_data,       32'h1234);
    chk("t1_out_ctrl",  32'(out_ctrl),  32'h00A5);
    drive(1'b0, 32'h0, 16'h0);
    tick();
    chk("t1_drained_valid", 32'(out_valid), 32'd0);
    chk("t1_drained_ctrl",  32'(out_ctrl),  32'(BUB));

    // Streaming 8 beats at full rate
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i), 16'(i));
      tick();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_data",  out_data,       32'(i));
      chk("stream_ready", 32'(in_ready),  32'd1);
    end
    drive(1'b0, 32'h0, 16'h0);
    tick();
    chk("stream_end_valid", 32'(out_valid), 32'd0);

    // Fill skid under backpressure, then drain in order
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 16'h000A);
    tick();
    drive(1'b1, 32'hB, 16'h000B);
    tick();
    chk("full_in_ready",  32'(in_ready),  32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_out_data",  out_data,       32'hA);
    drive(1'b0, 32'h0, 16'h0);
    out_ready = 1'b1;
    tick();
    chk("drain_b_valid", 32'(out_valid), 32'd1);
    chk("drain_b_data",  out_data,       32'hB);
    chk("drain_b_ctrl",  32'(out_ctrl),  32'h000B);
    chk("drain_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("drain_done_valid", 32'(out_valid), 32'd0);

    // Flush while FULL with input offered
    out_ready = 1'b0;
    drive(1'b1, 32'hD, 16'h000D);
    tick();
    drive(1'b1, 32'hE, 16'h000E);
    tick();
    chk("pre_flush_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 32'hC, 16'h000C);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 16'h0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_out_ctrl",  32'(out_ctrl),  32'(BUB));
    chk("flush_out_data",  out_data,       DRST);
    chk("flush_in_ready",  32'(in_ready),  32'd1);

    // Flush in ONE drops a simultaneous accepted input
    drive(1'b1, 32'hF, 16'h000F);
    tick();
    drive(1'b1, 32'h77, 16'h0077);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 16'h0);
    out_ready = 1'b1;
    chk("flush1_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("flush1_nothing_a", 32'(out_valid), 32'd0);
    tick();
    chk("flush1_nothing_b", 32'(out_valid), 32'd0);

    // Asynchronous reset between edges while FULL
    out_ready = 1'b0;
    drive(1'b1, 32'h55, 16'h0055);
    tick();
    drive(1'b1, 32'h56, 16'h0056);
    tick();
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready",  32'(in_ready),  32'd0);
    chk("arst_out_ctrl",  32'(out_ctrl),  32'(BUB));
    chk("arst_out_data",  out_data,       DRST);
    drive(1'b0, 32'h0, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("arst_rel_in_ready",  32'(in_ready),  32'd1);
    chk("arst_rel_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("arst_no_stale", 32'(out_valid), 32'd0);

`ifdef PIPE_STAGE_PERF_EN
    // Five stall cycles, then a flush that kills the held entry
    out_ready = 1'b0;
    drive(1'b1, 32'h99, 16'h0099);
    tick();
    drive(1'b0, 32'h0, 16'h0);
    repeat (5) tick();
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("perf_stall", perf_stall_cnt, 32'd5);
    chk("perf_flush", perf_flush_cnt, 32'd1);
    chk("perf_bp",    perf_bp_cnt,    32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
